// File: rtl/ocmkai_swio_controller.sv
// rtl/ocmkai_swio_controller.sv - switched-I/O port controller routing host 0x40-0x4F accesses to one of four device slots
// Optional build macro: OCMKAI_SWIO_TIMEOUT_EN adds a device-ack timeout counter in the forwarding state.
module ocmkai_swio_controller #(
  parameter logic [7:0] DEV0_ID        = 8'd213,
  parameter logic [7:0] DEV1_ID        = 8'd8,
  parameter logic [7:0] DEV2_ID        = 8'd212,
  parameter logic [7:0] DEV3_ID        = 8'd254,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic        clk21m,
  input  logic        reset_n,
  input  logic        req,
  output logic        ack,
  input  logic        wrt,
  input  logic [7:0]  adr,
  input  logic [7:0]  dbo,
  output logic [7:0]  dbi,
  output logic [3:0]  dev_req,
  input  logic [3:0]  dev_ack,
  output logic        dev_wrt,
  output logic [3:0]  dev_adr,
  output logic [7:0]  dev_dbo,
  input  logic [31:0] dev_dbi,
  output logic [7:0]  sel_id,
  output logic        sel_valid
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCAL,
    ST_FWD,
    ST_DONE,
    ST_RELEASE
  } state_t;

  state_t      r_state;
  logic        r_loc_wrt;
  logic        r_loc_is_id;
  logic [7:0]  r_loc_data;
  logic [1:0]  r_slot;

  logic        w_hit;
  logic [1:0]  w_cur_slot;
  logic        w_new_valid;
  logic [3:0]  w_slot_onehot;
  logic [7:0]  w_slot_dbi;
  logic        w_slot_ack;
  logic        w_timeout;

  // The counter is 7 bits wide, so the limit must fit 1..128 cycles.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 128) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be in 1..128");
  end

  // True when an ID equals any slot's ID.
  function automatic logic id_valid(input logic [7:0] id);
    return (id == DEV0_ID) || (id == DEV1_ID) || (id == DEV2_ID) || (id == DEV3_ID);
  endfunction

  // Slot index for an ID; lower slots win when IDs are duplicated.
  function automatic logic [1:0] id_slot(input logic [7:0] id);
    logic [1:0] s;
    if (id == DEV0_ID)      s = 2'd0;
    else if (id == DEV1_ID) s = 2'd1;
    else if (id == DEV2_ID) s = 2'd2;
    else                    s = 2'd3;
    return s;
  endfunction

  assign w_hit         = req && (adr[7:4] == 4'h4);
  assign w_cur_slot    = id_slot(sel_id);
  assign w_new_valid   = id_valid(r_loc_data);
  assign w_slot_onehot = 4'b0001 << r_slot;
  assign w_slot_dbi    = dev_dbi[{r_slot, 3'b000} +: 8];
  // Only an ack from the slot currently being driven counts.
  assign w_slot_ack    = dev_ack[r_slot] && dev_req[r_slot];

`ifdef OCMKAI_SWIO_TIMEOUT_EN
  localparam logic [6:0] TO_LAST = 7'(TIMEOUT_CYCLES - 1);
  logic [6:0] r_to_cnt;

  // Count cycles spent with a device request outstanding and unanswered.
  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else if ((r_state == ST_FWD) && (dev_req != 4'b0000) && !w_slot_ack) begin
      r_to_cnt <= r_to_cnt + 7'd1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == ST_FWD) && (dev_req != 4'b0000) && !w_slot_ack &&
                     (r_to_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // Access sequencer: accepts a host request, serves it locally or via a slot, acks once.
  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      ack         <= 1'b0;
      dbi         <= 8'hFF;
      dev_req     <= 4'b0000;
      dev_wrt     <= 1'b0;
      dev_adr     <= 4'h0;
      dev_dbo     <= 8'h00;
      sel_id      <= 8'h00;
      sel_valid   <= 1'b0;
      r_loc_wrt   <= 1'b0;
      r_loc_is_id <= 1'b0;
      r_loc_data  <= 8'h00;
      r_slot      <= 2'd0;
    end else begin
      ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            if ((adr[3:0] != 4'h0) && sel_valid) begin
              // Slot is chosen from the ID as it stands when the request is accepted.
              r_slot  <= w_cur_slot;
              dev_wrt <= wrt;
              dev_adr <= adr[3:0];
              dev_dbo <= dbo;
              r_state <= ST_FWD;
            end else begin
              r_loc_wrt   <= wrt;
              r_loc_is_id <= (adr[3:0] == 4'h0);
              r_loc_data  <= dbo;
              r_state     <= ST_LOCAL;
            end
          end
        end
        ST_LOCAL: begin
          if (r_loc_wrt) begin
            // Writes to unmatched ports 0x41-0x4F are silently dropped.
            if (r_loc_is_id) begin
              sel_id    <= r_loc_data;
              sel_valid <= w_new_valid;
            end
          end else begin
            dbi <= (r_loc_is_id && sel_valid) ? ~sel_id : 8'hFF;
          end
          r_state <= ST_DONE;
        end
        ST_FWD: begin
          if (w_slot_ack) begin
            dev_req <= 4'b0000;
            dbi     <= w_slot_dbi;
            r_state <= ST_DONE;
          end else if (w_timeout) begin
            dev_req <= 4'b0000;
            dbi     <= 8'hFF;
            r_state <= ST_DONE;
          end else if (dev_req == 4'b0000) begin
            // Device request goes out one cycle after acceptance.
            dev_req <= w_slot_onehot;
          end
        end
        ST_DONE: begin
          ack     <= 1'b1;
          r_state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Hold here until the host drops req so a held request acks only once.
          if (!req) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ocmkai_swio_controller.sv
// tb/tb_ocmkai_swio_controller.sv - directed self-checking bench for ocmkai_swio_controller
module tb_ocmkai_swio_controller;

  logic        clk21m  = 1'b0;
  logic        reset_n = 1'b0;
  logic        req     = 1'b0;
  logic        wrt     = 1'b0;
  logic [7:0]  adr     = 8'h00;
  logic [7:0]  dbo     = 8'h00;
  logic [3:0]  dev_ack = 4'h0;
  logic [31:0] dev_dbi = 32'h0;
  logic        ack;
  logic [7:0]  dbi;
  logic [3:0]  dev_req;
  logic        dev_wrt;
  logic [3:0]  dev_adr;
  logic [7:0]  dev_dbo;
  logic [7:0]  sel_id;
  logic        sel_valid;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk21m = ~clk21m;

  ocmkai_swio_controller dut (
    .clk21m   (clk21m),
    .reset_n  (reset_n),
    .req      (req),
    .ack      (ack),
    .wrt      (wrt),
    .adr      (adr),
    .dbo      (dbo),
    .dbi      (dbi),
    .dev_req  (dev_req),
    .dev_ack  (dev_ack),
    .dev_wrt  (dev_wrt),
    .dev_adr  (dev_adr),
    .dev_dbo  (dev_dbo),
    .dev_dbi  (dev_dbi),
    .sel_id   (sel_id),
    .sel_valid(sel_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk21m);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"}, ack, 1'b0);
    check({tag, "_dbi"}, dbi, 8'hFF);
    check({tag, "_dev_req"}, dev_req, 4'h0);
    check({tag, "_dev_wrt"}, dev_wrt, 1'b0);
    check({tag, "_dev_adr"}, dev_adr, 4'h0);
    check({tag, "_dev_dbo"}, dev_dbo, 8'h00);
    check({tag, "_sel_id"}, sel_id, 8'h00);
    check({tag, "_sel_valid"}, sel_valid, 1'b0);
  endtask

  // Local access: req held past the ack, expect one ack at edge N+2 and no device request.
  task automatic host_local(input string tag, input logic w, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] exp_dbi);
    int lat = 0;
    int acks = 0;
    logic [7:0] got = 8'h00;
    logic any_req = 1'b0;
    req = 1'b1; wrt = w; adr = a; dbo = d;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (dev_req != 4'h0) any_req = 1'b1;
      if (ack) begin
        acks++;
        if (lat == 0) begin lat = i; got = dbi; end
      end
      if (i == 5) req = 1'b0;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_ack_count"}, acks, 1);
    check({tag, "_no_dev_req"}, any_req, 1'b0);
    if (!w) check({tag, "_dbi"}, got, exp_dbi);
  endtask

  // Forwarded access: device answers after ack_delay cycles while other slots ack as noise.
  task automatic host_fwd(input string tag, input logic w, input logic [7:0] a,
                          input logic [7:0] d, input logic [3:0] onehot,
                          input int ack_delay, input logic [7:0] exp_dbi);
    req = 1'b1; wrt = w; adr = a; dbo = d;
    tick();
    check({tag, "_req_n"}, dev_req, 4'h0);
    tick();
    check({tag, "_req_n1"}, dev_req, onehot);
    check({tag, "_wrt"}, dev_wrt, w);
    check({tag, "_adr"}, dev_adr, a[3:0]);
    check({tag, "_dbo"}, dev_dbo, d);
    dev_ack = ~onehot;
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      check({tag, "_hold_req"}, dev_req, onehot);
      check({tag, "_no_early_ack"}, ack, 1'b0);
    end
    dev_ack = onehot;
    tick();
    dev_ack = 4'h0;
    check({tag, "_req_drop"}, dev_req, 4'h0);
    check({tag, "_ack_m"}, ack, 1'b0);
    tick();
    check({tag, "_ack_m1"}, ack, 1'b1);
    check({tag, "_dbi"}, dbi, exp_dbi);
    tick();
    check({tag, "_ack_single"}, ack, 1'b0);
    req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int acks;
    logic any_req;

    tick();
    tick();
    check_reset_values("reset");
    reset_n = 1'b1;
    tick();

    host_local("wr40_213", 1'b1, 8'h40, 8'd213, 8'h00);
    check("sel_id_213", sel_id, 8'd213);
    check("sel_valid_213", sel_valid, 1'b1);
    host_local("rd40", 1'b0, 8'h40, 8'h00, 8'h2A);

    dev_dbi = 32'hA1B2C3D4;
    host_fwd("fwd_wr41", 1'b1, 8'h41, 8'h02, 4'b0001, 3, 8'hD4);
    dev_dbi = 32'h11223344;
    host_fwd("fwd_rd4a", 1'b0, 8'h4A, 8'h00, 4'b0001, 1, 8'h44);

    host_local("wr40_123", 1'b1, 8'h40, 8'd123, 8'h00);
    check("sel_id_123", sel_id, 8'd123);
    check("sel_valid_123", sel_valid, 1'b0);
    host_local("rd42_unmatched", 1'b0, 8'h42, 8'h00, 8'hFF);
    host_local("rd40_unmatched", 1'b0, 8'h40, 8'h00, 8'hFF);

    acks = 0; any_req = 1'b0;
    req = 1'b1; wrt = 1'b0; adr = 8'h50;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack) acks++;
      if (dev_req != 4'h0) any_req = 1'b1;
    end
    req = 1'b0;
    tick();
    check("adr50_ack", acks, 0);
    check("adr50_dev_req", any_req, 1'b0);

    host_local("wr40_8", 1'b1, 8'h40, 8'd8, 8'h00);
    check("sel_valid_8", sel_valid, 1'b1);
    req = 1'b1; wrt = 1'b0; adr = 8'h43;
    tick();
    tick();
    check("slot1_req", dev_req, 4'b0010);
`ifdef OCMKAI_SWIO_TIMEOUT_EN
    acks = 0;
    for (int i = 0; i < 80 && acks == 0; i++) begin
      tick();
      if (ack) acks++;
    end
    check("timeout_ack", acks, 1);
    check("timeout_dbi", dbi, 8'hFF);
    check("timeout_dev_req", dev_req, 4'h0);
    req = 1'b0;
    tick();
    tick();
    req = 1'b1; adr = 8'h43;
    tick();
    tick();
    check("slot1_req_again", dev_req, 4'b0010);
`else
    acks = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (ack) acks++;
    end
    check("no_timeout_ack", acks, 0);
    check("no_timeout_dev_req", dev_req, 4'b0010);
`endif
    #2 reset_n = 1'b0;
    #1;
    check_reset_values("reset_mid_fwd");
    req = 1'b0;
    tick();
    check("reset_hold_ack", ack, 1'b0);
    reset_n = 1'b1;
    tick();

    host_local("wr40_8_again", 1'b1, 8'h40, 8'd8, 8'h00);
    check("sel_valid_again", sel_valid, 1'b1);
    check("sel_id_again", sel_id, 8'd8);
    dev_dbi = 32'h0000C300;
    host_fwd("fwd_rd4f_slot1", 1'b0, 8'h4F, 8'h00, 4'b0010, 2, 8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ocmkai_swio_controller.md
OCMKAI_SWIO_CONTROLLER -- requirements
Module: ocmkai_swio_controller

Interface
REQ-001 SHALL have parameter DEV0_ID, default 8'd213, switched-I/O ID of device slot 0.
REQ-002 SHALL have parameter DEV1_ID, default 8'd8, ID of slot 1.
REQ-003 SHALL have parameter DEV2_ID, default 8'd212, ID of slot 2.
REQ-004 SHALL have parameter DEV3_ID, default 8'd254, ID of slot 3.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 64, device-ack wait limit.
REQ-006 SHALL have ports, clock and reset first:
- clk21m  in  1  system clock (21.48 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  host I/O request, held high until ack seen.
- ack  out  1  host acknowledge, one-cycle pulse.
- wrt  in  1  1=write, 0=read.
- adr  in  8  host I/O port address.
- dbo  in  8  host write data.
- dbi  out  8  host read data, valid while ack=1.
- dev_req  out  4  per-slot request, one-hot.
- dev_ack  in  4  per-slot acknowledge.
- dev_wrt  out  1  forwarded wrt.
- dev_adr  out  4  forwarded adr[3:0].
- dev_dbo  out  8  forwarded write data.
- dev_dbi  in  32  slot k read data on bits [8k+7:8k].
- sel_id  out  8  current ID register.
- sel_valid  out  1  sel_id matches a slot.

Function
REQ-007 SHALL respond only when adr[7:4]==4'h4; other addresses: no ack, no dev_req, state unchanged.
REQ-008 SHALL run FSM IDLE, LOCAL, FWD, DONE, RELEASE.
REQ-009 IDLE: req=1 sampled at edge N with adr=0x40, or adr 0x41-0x4F with no slot matched -> LOCAL; adr 0x41-0x4F with a slot matched -> FWD.
REQ-010 LOCAL: write to 0x40 loads sel_id<=dbo; read of 0x40 returns ~sel_id when sel_valid=1, else 0xFF; unmatched 0x41-0x4F write is dropped, read returns 0xFF; -> DONE.
REQ-011 FWD: dev_req[k]=1 for matched slot k from edge N+1; dev_wrt/dev_adr/dev_dbo registered from the host request and stable throughout; on dev_ack[k]=1 sampled at edge M, drop dev_req[k], latch dev_dbi slot k into dbi -> DONE.
REQ-012 DONE: ack=1 for exactly one cycle -> RELEASE.
REQ-013 RELEASE: wait for req=0, then IDLE; a held req SHALL produce exactly one ack.
REQ-014 Latency: local access ack rises at edge N+2; forwarded ack rises at edge M+1.
REQ-015 dev_ack on non-selected slots, or outside FWD, SHALL be ignored.
REQ-016 sel_id written during an access SHALL take effect for the next access only; match is slot-priority 0>1>2>3 on duplicate IDs.
REQ-017 At most one dev_req bit SHALL ever be high.

Reset
REQ-018 reset_n=0 SHALL immediately force: FSM=IDLE, ack=0, dbi=8'hFF, dev_req=0, dev_wrt=0, dev_adr=0, dev_dbo=0, sel_id=8'h00, sel_valid=0, timeout counter=0.
REQ-019 Reset during FWD SHALL drop dev_req with no ack issued; first request after release is served normally.

Configuration
REQ-020 Macro OCMKAI_SWIO_TIMEOUT_EN defined: a 7-bit counter runs in FWD; after TIMEOUT_CYCLES cycles without dev_ack, drop dev_req, set dbi=0xFF -> DONE.
REQ-021 Macro undefined: no counter; FWD waits indefinitely for dev_ack.

Verification
REQ-022 Write 0x40=213 -> sel_id=213, sel_valid=1, ack at edge N+2; read 0x40 -> dbi=0x2A.
REQ-023 After REQ-022, write 0x41=2 (req held 4 cycles), dev_ack[0] after 3 cycles -> dev_req=4'b0001, dev_adr=1, dev_dbo=2, single host ack one cycle after dev_ack.
REQ-024 sel_id=123 (unmatched), read 0x42 -> dbi=0xFF, ack at N+2, dev_req stays 0; read 0x40 -> 0xFF.
REQ-025 With OCMKAI_SWIO_TIMEOUT_EN, slot 1 selected, never ack -> dev_req drops after 64 cycles, ack with dbi=0xFF; without macro, no ack after 1000 cycles.
REQ-026 reset_n=0 mid-FWD -> all outputs at reset values same cycle; then write 0x40=8 -> sel_valid=1, slot 1 selected.
REQ-027 Request to adr 0x50 -> no ack and no dev_req over 20 cycles.
